set_count_gen: RTL
==================

SET_COUNT_GEN -- requirements
Module: set_count_gen

Interface
REQ-001 Parameter GRID, default 8, meaning grid edge; points (x,y) with x,y in 1..GRID are scanned.
REQ-002 Parameter CW, default 4, meaning coordinate/radius field width; GRID SHALL be <= 2^CW-1.
REQ-003 Parameter NC, default 3, meaning circle count; NC SHALL be >= 2.
REQ-004 Parameter CNTW, default 8, meaning candidate width; GRID*GRID SHALL be < 2^CNTW.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 en  input  1  start request; sampled only while busy=0.
REQ-008 central  input  2*CW*NC  circle k centre at [2*CW*k +: 2*CW], x in upper CW bits, y in lower CW bits.
REQ-009 radius  input  CW*NC  circle k radius at [CW*k +: CW].
REQ-010 mode  input  3  set-operation select, latched with en.
REQ-011 busy  output  1  job in progress.
REQ-012 valid  output  1  one-cycle result strobe.
REQ-013 candidate  output  CNTW  point count.

Function
REQ-014 Circle naming: A = circle NC-1, B = circle NC-2, C = circle NC-3 (when NC >= 3).
REQ-015 Membership of circle k: (x-cx)^2+(y-cy)^2 <= r^2, using absolute differences, exact arithmetic at 2*CW+1 bits, no truncation; r=0 admits only the centre.
REQ-016 mode 000: in A; 001: A and B; 010: A xor B; 011: exactly two of A,B,C (NC >= 3, else count 0); 100: in any of the NC circles; 101: in all NC circles; 110: in exactly one of the NC circles; 111: reserved, count SHALL be 0.
REQ-017 FSM states IDLE, SCAN, DONE; reset state IDLE.
REQ-018 IDLE: busy=0; en=1 at an edge latches central, radius, mode, clears candidate to 0, sets x=y=1, enters SCAN; busy=1 from next cycle.
REQ-019 SCAN: one point per cycle, row-major, x fastest (1,1),(2,1)..(GRID,1),(1,2)..(GRID,GRID); candidate increments by 1 when the current point satisfies the mode.
REQ-020 After point (GRID,GRID) is evaluated, FSM enters DONE; valid=1, busy=1 and candidate final in that DONE cycle, exactly GRID*GRID+1 cycles after the cycle busy first reads 1.
REQ-021 DONE lasts exactly one cycle, then IDLE: valid=0, busy=0.
REQ-022 candidate SHALL hold its final value in IDLE until the next accepted en.
REQ-023 en while busy=1 (SCAN or DONE) SHALL be ignored; latched inputs SHALL NOT change during a job.
REQ-024 Input changes on central/radius/mode outside the accepting edge SHALL NOT affect the result.
REQ-025 Earliest back-to-back start: en=1 on the first IDLE cycle after DONE.
REQ-026 candidate SHALL never wrap (guaranteed by REQ-004).

Reset
REQ-027 rst=1 SHALL immediately force IDLE, busy=0, valid=0, candidate=0, x=y=1, and clear latched circles and mode, including mid-SCAN and during DONE.
REQ-028 After rst deasserts, no job SHALL start without a new en.

Verification (GRID=8, CW=4, NC=3; circles listed A,B,C)
REQ-029 mode 000, A=(4,4) r=2 -> valid pulse with candidate=13, 65 cycles after busy rises.
REQ-030 mode 000, A=(1,1) r=2 -> 6; A=(8,8) r=15 -> 64; A=(5,5) r=0 -> 1.
REQ-031 A=(4,4) r=1, B=(5,4) r=1, C=(8,8) r=0: mode 001 -> 2; 010 -> 6; 100 -> 9; 011 -> 2; 101 -> 0; 110 -> 7; 111 -> 0.
REQ-032 en pulsed again at SCAN cycle 10 with different inputs -> ignored, first job result unchanged; en on first IDLE cycle after DONE -> new job starts, candidate cleared.
REQ-033 rst asserted at SCAN cycle 30 -> busy, valid, candidate all 0 immediately; no valid pulse until a new en; next job returns correct count.
REQ-034 Parameter sweep GRID=4, NC=2, CNTW=5, mode 101, A=(2,2) r=3, B=(3,3) r=3 -> candidate equals reference-model count; mode 011 -> 0.

Source files
------------

// File: rtl/set_count_gen.sv
// set_count_gen: scans a GRID x GRID lattice one point per cycle and counts
// the points that satisfy a set relation between up to NC latched circles.
// A job starts on en in IDLE. The result is presented with a one-cycle valid
// strobe in DONE and is then held until the next job is accepted.
module set_count_gen #(
  parameter int GRID = 8,
  parameter int CW   = 4,
  parameter int NC   = 3,
  parameter int CNTW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [2*CW*NC-1:0]   central,
  input  logic [CW*NC-1:0]     radius,
  input  logic [2:0]           mode,
  output logic                 busy,
  output logic                 valid,
  output logic [CNTW-1:0]      candidate
);

  // Squared distances need one bit more than a squared coordinate difference.
  localparam int  SW    = 2*CW+1;
  localparam int  OW    = $clog2(NC+1);
  localparam bit  HAS_C = (NC >= 3);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      x_reg, y_reg;
  logic [2*CW*NC-1:0] central_reg;
  logic [CW*NC-1:0]   radius_reg;
  logic [2:0]         mode_reg;
  logic [CNTW-1:0]    cnt_reg;

  logic [NC-1:0]      hit;
  logic [OW-1:0]      ones;
  logic               a_hit, b_hit, c_hit;
  logic               point_ok;
  logic               last_point;

  // Per-circle membership test for the current scan point.
  genvar gi;
  generate
    for (gi = 0; gi < NC; gi++) begin : g_circle
      logic [CW-1:0] cx, cy, r, dx, dy;
      logic [SW-1:0] dxe, dye, re, dist2, r2;
      assign cx    = central_reg[2*CW*gi+CW +: CW];
      assign cy    = central_reg[2*CW*gi +: CW];
      assign r     = radius_reg[CW*gi +: CW];
      assign dx    = (x_reg >= cx) ? (x_reg - cx) : (cx - x_reg);
      assign dy    = (y_reg >= cy) ? (y_reg - cy) : (cy - y_reg);
      assign dxe   = SW'(dx);
      assign dye   = SW'(dy);
      assign re    = SW'(r);
      assign dist2 = dxe*dxe + dye*dye;
      assign r2    = re*re;
      assign hit[gi] = (dist2 <= r2);
    end
  endgenerate

  assign a_hit = hit[NC-1];
  assign b_hit = hit[NC-2];

  // Circle C only exists with three or more circles.
  generate
    if (HAS_C) begin : g_has_c
      assign c_hit = hit[NC-3];
    end else begin : g_no_c
      assign c_hit = 1'b0;
    end
  endgenerate

  assign last_point = (x_reg == CW'(GRID)) && (y_reg == CW'(GRID));

  // Number of circles containing the current point.
  always_comb begin
    ones = '0;
    for (int i = 0; i < NC; i++) begin
      ones = ones + OW'(hit[i]);
    end
  end

  // Set-operation selection for the current point.
  always_comb begin
    point_ok = 1'b0;
    case (mode_reg)
      3'b000:  point_ok = a_hit;
      3'b001:  point_ok = a_hit & b_hit;
      3'b010:  point_ok = a_hit ^ b_hit;
      3'b011:  point_ok = HAS_C & ((a_hit & b_hit & ~c_hit) |
                                   (a_hit & ~b_hit & c_hit) |
                                   (~a_hit & b_hit & c_hit));
      3'b100:  point_ok = (ones != '0);
      3'b101:  point_ok = (ones == OW'(NC));
      3'b110:  point_ok = (ones == OW'(1));
      default: point_ok = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and status outputs.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    valid      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (en) state_next = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (last_point) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        valid      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Job inputs, scan position and running count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      central_reg <= '0;
      radius_reg  <= '0;
      mode_reg    <= '0;
      cnt_reg     <= '0;
      x_reg       <= CW'(1);
      y_reg       <= CW'(1);
    end else begin
      case (state_reg)
        IDLE: begin
          if (en) begin
            central_reg <= central;
            radius_reg  <= radius;
            mode_reg    <= mode;
            cnt_reg     <= '0;
            x_reg       <= CW'(1);
            y_reg       <= CW'(1);
          end
        end
        SCAN: begin
          if (point_ok) cnt_reg <= cnt_reg + CNTW'(1);
          if (x_reg == CW'(GRID)) begin
            x_reg <= CW'(1);
            y_reg <= last_point ? CW'(1) : (y_reg + CW'(1));
          end else begin
            x_reg <= x_reg + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign candidate = cnt_reg;

endmodule
